plru_replace: RTL and testbench

- Stage directly downstream of the cache hit/miss detector in the set-associative cache.
- Consumes the per-access hit/miss result and way select for one set, and keeps a tree pseudo-LRU (PLRU) state per set.
- Produces the way to use: the hit way, the invalid way being filled, or an eviction victim.
- Updates that set's PLRU state once per accepted request.

---
 rtl/plru_replace_pkg.sv | 56 +++++
 rtl/plru_replace_if.sv | 33 +++
 rtl/plru_replace_plru_tree.sv | 16 +
 rtl/plru_replace.sv | 112 +++++++++++
 tb/tb_plru_replace.sv | 133 +++++++++++++
 5 files changed

// File: rtl/plru_replace_pkg.sv
// Shared geometry, types, FSM encoding and tree-PLRU helper functions
// for the PLRU replacement stage.
package plru_replace_pkg;

   // Cache geometry (log2 widths except A_SIZE)
   localparam int unsigned I_SIZE = 32;
   localparam int unsigned C_SIZE = 24;
   localparam int unsigned D_SIZE = 6;
   localparam int unsigned A_SIZE = 8;

   localparam int unsigned W = $clog2(A_SIZE);
   localparam int unsigned S = C_SIZE - D_SIZE - W;
   localparam int unsigned N = A_SIZE - 1;

   typedef logic [N-1:0] plru_t;
   typedef logic [W-1:0] way_t;
   typedef logic [S-1:0] index_t;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      RESP
   } state_t;

   // Follow the tree from the root: bit 0 steers left, bit 1 steers right.
   function automatic way_t plru_victim(plru_t bits);
      int unsigned node;
      logic        b;
      way_t        way;
      node = 0;
      way  = '0;
      for (int unsigned lvl = 0; lvl < W; lvl++) begin
         b      = bits[node];
         way    = way << 1;
         way[0] = b;
         node   = 2 * node + 1 + 32'(b);
      end
      return way;
   endfunction

   // Point every node on the accessed way's path away from that way.
   function automatic plru_t plru_update(plru_t bits, way_t way);
      int unsigned node;
      logic        b;
      plru_t       nxt;
      node = 0;
      nxt  = bits;
      for (int unsigned lvl = 0; lvl < W; lvl++) begin
         b         = way[W-1-lvl];
         nxt[node] = ~b;
         node      = 2 * node + 1 + 32'(b);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/plru_replace_if.sv
// Request/response bundle between the hit/miss detector, the PLRU stage
// and the fill/eviction consumer.
interface plru_replace_if import plru_replace_pkg::*; ();

   logic   req_valid;
   logic   req_ready;
   index_t req_index;
   logic   hit;
   logic   miss;
   way_t   block_select;
   logic   all_ways_valid;

   logic   resp_valid;
   logic   resp_ready;
   way_t   victim_way;
   logic   evict;
   logic   err;

   // Requester / response consumer side
   modport master (
      output req_valid, req_index, hit, miss, block_select, all_ways_valid,
      output resp_ready,
      input  req_ready, resp_valid, victim_way, evict, err
   );

   // PLRU replacement block side
   modport slave (
      input  req_valid, req_index, hit, miss, block_select, all_ways_valid,
      input  resp_ready,
      output req_ready, resp_valid, victim_way, evict, err
   );

endinterface

// File: rtl/plru_replace_plru_tree.sv
// Combinational tree-PLRU evaluation for one set: victim from the current
// bits, and the bits after an access to the given way.
module plru_tree import plru_replace_pkg::*; (
   input  plru_t plru_cur,
   input  way_t  access_way,
   output way_t  victim,
   output plru_t plru_next
);

   // Victim search and update are independent pure functions of the inputs
   always_comb begin
      victim    = plru_victim(plru_cur);
      plru_next = plru_update(plru_cur, access_way);
   end

endmodule

// File: rtl/plru_replace.sv
// Tree pseudo-LRU replacement stage: holds per-set PLRU bits, accepts one
// hit/miss result at a time and returns the way to use.
module plru_replace import plru_replace_pkg::*; (
   input  logic         clk,
   input  logic         rst_n,
   plru_replace_if.slave bus
);

   localparam int unsigned SETS = 2 ** S;

   state_t state_q, state_d;

   index_t index_q;
   logic   hit_q;
   logic   miss_q;
   way_t   sel_q;
   logic   avw_q;

   way_t   victim_q;
   logic   evict_q;
   logic   err_q;

   plru_t  plru_mem [SETS];

   plru_t  cur_bits;
   plru_t  next_bits;
   way_t   tree_victim;
   way_t   access_way;
   logic   bad_enc;
   logic   use_victim;

   // Decode of the latched request and PLRU read for the LOOKUP datapath
   always_comb begin
      cur_bits   = plru_mem[index_q];
      bad_enc    = (hit_q == miss_q);
      use_victim = miss_q & ~hit_q & avw_q;
      access_way = use_victim ? tree_victim : sel_q;
   end

   plru_tree u_tree (
      .plru_cur   (cur_bits),
      .access_way (access_way),
      .victim     (tree_victim),
      .plru_next  (next_bits)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.req_valid) state_d = LOOKUP;
         LOOKUP:  state_d = RESP;
         RESP:    if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture on accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         index_q <= '0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         sel_q   <= '0;
         avw_q   <= 1'b0;
      end else if (state_q == IDLE && bus.req_valid) begin
         index_q <= bus.req_index;
         hit_q   <= bus.hit;
         miss_q  <= bus.miss;
         sel_q   <= bus.block_select;
         avw_q   <= bus.all_ways_valid;
      end
   end

   // Registered result, updated only when leaving LOOKUP
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         victim_q <= '0;
         evict_q  <= 1'b0;
         err_q    <= 1'b0;
      end else if (state_q == LOOKUP) begin
         victim_q <= bad_enc ? '0 : access_way;
         evict_q  <= use_victim;
         err_q    <= bad_enc;
      end
   end

   // Per-set PLRU storage; only the indexed set is written, and not on error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SETS; i++) plru_mem[i] <= '0;
      end else if (state_q == LOOKUP && !bad_enc) begin
         plru_mem[index_q] <= next_bits;
      end
   end

   // Handshake outputs, forced low while reset is asserted
   always_comb begin
      bus.req_ready  = rst_n & (state_q == IDLE);
      bus.resp_valid = rst_n & (state_q == RESP);
      bus.victim_way = victim_q;
      bus.evict      = evict_q;
      bus.err        = err_q;
   end

endmodule

// File: tb/tb_plru_replace.sv
// Directed bench for plru_replace with hand-computed PLRU expectations.
module tb_plru_replace;
   import plru_replace_pkg::*;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   plru_replace_if bus_if ();

   plru_replace dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request with fixed 2-cycle latency; response held for hold cycles.
   task automatic txn(input string tag, input index_t idx, input logic h, input logic m,
                      input way_t bs, input logic avw, input way_t exp_way,
                      input logic exp_ev, input logic exp_err, input int hold);
      bus_if.req_valid      = 1'b1;
      bus_if.req_index      = idx;
      bus_if.hit            = h;
      bus_if.miss           = m;
      bus_if.block_select   = bs;
      bus_if.all_ways_valid = avw;
      chk({tag, ".ready_idle"}, 32'(bus_if.req_ready), 32'd1);
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      chk({tag, ".ready_lookup"}, 32'(bus_if.req_ready), 32'd0);
      chk({tag, ".rvalid_lookup"}, 32'(bus_if.resp_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".rvalid"}, 32'(bus_if.resp_valid), 32'd1);
      chk({tag, ".way"}, 32'(bus_if.victim_way), 32'(exp_way));
      chk({tag, ".evict"}, 32'(bus_if.evict), 32'(exp_ev));
      chk({tag, ".err"}, 32'(bus_if.err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         bus_if.req_valid = 1'b1;
         @(posedge clk); #1;
         chk({tag, ".hold_rvalid"}, 32'(bus_if.resp_valid), 32'd1);
         chk({tag, ".hold_ready"}, 32'(bus_if.req_ready), 32'd0);
         chk({tag, ".hold_way"}, 32'(bus_if.victim_way), 32'(exp_way));
         chk({tag, ".hold_evict"}, 32'(bus_if.evict), 32'(exp_ev));
      end
      bus_if.req_valid  = 1'b0;
      bus_if.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.resp_ready = 1'b0;
      chk({tag, ".rvalid_done"}, 32'(bus_if.resp_valid), 32'd0);
      chk({tag, ".way_kept"}, 32'(bus_if.victim_way), 32'(exp_way));
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus_if.req_valid      = 1'b0;
      bus_if.req_index      = '0;
      bus_if.hit            = 1'b0;
      bus_if.miss           = 1'b0;
      bus_if.block_select   = '0;
      bus_if.all_ways_valid = 1'b0;
      bus_if.resp_ready     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst.ready", 32'(bus_if.req_ready), 32'd0);
      chk("rst.rvalid", 32'(bus_if.resp_valid), 32'd0);
      chk("rst.way", 32'(bus_if.victim_way), 32'd0);
      chk("rst.evict", 32'(bus_if.evict), 32'd0);
      chk("rst.err", 32'(bus_if.err), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst.ready", 32'(bus_if.req_ready), 32'd1);
      @(posedge clk); #1;

      // Set 5: successive evictions walk 0 -> 4 -> 2
      txn("s5_ev0", 15'd5, 1'b0, 1'b1, 3'd7, 1'b1, 3'd0, 1'b1, 1'b0, 0);
      txn("s5_ev1", 15'd5, 1'b0, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0, 0);
      txn("s5_ev2", 15'd5, 1'b0, 1'b1, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0, 0);

      // Set 9: hit on way 3 steers the next victim to way 4
      txn("s9_hit", 15'd9, 1'b1, 1'b0, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0, 0);
      txn("s9_ev",  15'd9, 1'b0, 1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0, 0);

      // Set 2: fill invalid way 6, two bad encodings, then eviction -> way 0
      txn("s2_fill", 15'd2, 1'b0, 1'b1, 3'd6, 1'b0, 3'd6, 1'b0, 1'b0, 0);
      txn("s2_err11", 15'd2, 1'b1, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 0);
      txn("s2_err00", 15'd2, 1'b0, 1'b0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b1, 0);
      txn("s2_ev",   15'd2, 1'b0, 1'b1, 3'd3, 1'b1, 3'd0, 1'b1, 1'b0, 0);

      // Set 5 again (bits 1,0,1,1,1,1,0 for nodes 0..6): victim 6, response held
      txn("s5_hold", 15'd5, 1'b0, 1'b1, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 5);

      // Reset while a set-5 request is in LOOKUP
      bus_if.req_valid      = 1'b1;
      bus_if.req_index      = 15'd5;
      bus_if.hit            = 1'b0;
      bus_if.miss           = 1'b1;
      bus_if.all_ways_valid = 1'b1;
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("lk_rst.rvalid", 32'(bus_if.resp_valid), 32'd0);
      chk("lk_rst.ready", 32'(bus_if.req_ready), 32'd0);
      chk("lk_rst.way", 32'(bus_if.victim_way), 32'd0);
      chk("lk_rst.evict", 32'(bus_if.evict), 32'd0);
      @(posedge clk); #1;
      chk("lk_rst.rvalid2", 32'(bus_if.resp_valid), 32'd0);
      rst_n = 1'b1;
      #1;

      // Cleared set 5 evicts way 0 again (would be way 1 without the clear)
      txn("s5_after_rst", 15'd5, 1'b0, 1'b1, 3'd5, 1'b1, 3'd0, 1'b1, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
